// File: rtl/core_pkg.sv
// Shared constants and fetch FSM encoding for the RV32I core front end.
package core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, stall holds, otherwise load
// the accepted word or a bubble when nothing was accepted this cycle.
module if_id_reg #(
  parameter int               XLEN      = core_pkg::XLEN,
  parameter logic [31:0]      NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_load,
  input  logic [31:0]       i_instr,
  input  logic [XLEN-1:0]   i_pc,
  output logic [31:0]       o_instr,
  output logic [XLEN-1:0]   o_pc,
  output logic [XLEN-1:0]   o_pcPlus4,
  output logic              o_valid
);
  import core_pkg::*;

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pcPlus4;
  logic            r_valid;

  // Bubbles keep the last PC pair so downstream PC-relative logic sees stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= NOP_INSTR;
      r_pc      <= '0;
      r_pcPlus4 <= XLEN'(4);
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        r_instr   <= i_instr;
        r_pc      <= i_pc;
        r_pcPlus4 <= i_pc + XLEN'(4);
        r_valid   <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr   = r_instr;
  assign o_pc      = r_pc;
  assign o_pcPlus4 = r_pcPlus4;
  assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PC_F, drives the wait-stated instruction memory and feeds the
// IF/ID register; a redirect during an in-flight access drains it first.
module fetch_stage #(
  parameter int               XLEN      = core_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = core_pkg::RESET_PC,
  parameter logic [31:0]      NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_F,
  input  logic              stall_D,
  input  logic              flush_D,
  input  logic              jump,
  input  logic [XLEN-1:0]   pc_target_E,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [31:0]       instr_D,
  output logic [XLEN-1:0]   pc_D,
  output logic [XLEN-1:0]   pc_plus4_D,
  output logic              valid_D
);
  import core_pkg::*;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pcF;
  logic [XLEN-1:0] r_tgtQ;
  logic            r_imemReq;
  logic [XLEN-1:0] w_target;
  logic            w_accept;

  assign w_target = {pc_target_E[XLEN-1:2], 2'b00};
  assign w_accept = (r_state == FETCH) && imem_ready && !jump && !stall_F;

  // The address stays on PC_F while draining so the memory sees a stable request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pcF     <= RESET_PC;
      r_tgtQ    <= '0;
      r_imemReq <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state   <= FETCH;
          r_imemReq <= 1'b1;
        end
        FETCH: begin
          if (jump && imem_ready) begin
            r_pcF <= w_target;
          end else if (jump) begin
            r_tgtQ  <= w_target;
            r_state <= DRAIN;
          end else if (imem_ready && !stall_F) begin
            r_pcF <= r_pcF + XLEN'(4);
          end
        end
        DRAIN: begin
          if (jump) begin
            r_tgtQ <= w_target;
          end
          if (imem_ready) begin
            r_pcF   <= jump ? w_target : r_tgtQ;
            r_state <= FETCH;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_imemReq <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_imemReq;
  assign imem_addr = r_pcF;

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifId (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush_D),
    .i_stall   (stall_D),
    .i_load    (w_accept),
    .i_instr   (imem_rdata),
    .i_pc      (r_pcF),
    .o_instr   (instr_D),
    .o_pc      (pc_D),
    .o_pcPlus4 (pc_plus4_D),
    .o_valid   (valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a
// behavioural model of the fetch/redirect/IF-ID rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_F, stall_D, flush_D, jump;
  logic [31:0] pc_target_E;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr_D, pc_D, pc_plus4_D;
  logic        valid_D;

  int checks = 0;
  int failures = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
    .jump(jump), .pc_target_E(pc_target_E), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr_D(instr_D), .pc_D(pc_D),
    .pc_plus4_D(pc_plus4_D), .valid_D(valid_D)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  always_comb imem_rdata = imem_ready ? memWord(imem_addr) : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1; stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0; jump = 1'b0;
    pc_target_E = 32'h0; imem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0; jump = 1'b0;
    pc_target_E = 32'h0; imem_ready = 1'b1;
    #12;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req actual=%b expected=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr actual=%h expected=0", imem_addr); end
    checks++; if (instr_D !== NOP) begin failures++; $display("[TB] FAIL reset_instr actual=%h expected=%h", instr_D, NOP); end
    checks++; if (pc_D !== 32'h0) begin failures++; $display("[TB] FAIL reset_pcD actual=%h expected=0", pc_D); end
    checks++; if (pc_plus4_D !== 32'h4) begin failures++; $display("[TB] FAIL reset_pc4 actual=%h expected=4", pc_plus4_D); end
    checks++; if (valid_D !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b expected=0", valid_D); end
  endtask

  task automatic test_sequential();
    logic [31:0] ePc;
    resetDut();
    imem_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (imem_addr !== 32'(4 * (k - 1))) begin failures++; $display("[TB] FAIL seq_addr k=%0d actual=%h expected=%h", k, imem_addr, 32'(4 * (k - 1))); end
      checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL seq_req k=%0d actual=%b expected=1", k, imem_req); end
      if (k == 1) begin
        checks++; if (valid_D !== 1'b0) begin failures++; $display("[TB] FAIL seq_valid0 actual=%b expected=0", valid_D); end
      end else begin
        ePc = 32'(4 * (k - 2));
        checks++; if (valid_D !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid k=%0d actual=%b expected=1", k, valid_D); end
        checks++; if (instr_D !== memWord(ePc)) begin failures++; $display("[TB] FAIL seq_instr k=%0d actual=%h expected=%h", k, instr_D, memWord(ePc)); end
        checks++; if (pc_D !== ePc) begin failures++; $display("[TB] FAIL seq_pcD k=%0d actual=%h expected=%h", k, pc_D, ePc); end
        checks++; if (pc_plus4_D !== ePc + 32'd4) begin failures++; $display("[TB] FAIL seq_pc4 k=%0d actual=%h expected=%h", k, pc_plus4_D, ePc + 32'd4); end
      end
    end
  endtask

  task automatic test_wait_states();
    resetDut();
    imem_ready = 1'b1;
    repeat (3) tick();
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL wait_start actual=%h expected=8", imem_addr); end
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL wait_addr i=%0d actual=%h expected=8", i, imem_addr); end
      checks++; if (valid_D !== 1'b0) begin failures++; $display("[TB] FAIL wait_bubble i=%0d actual=%b expected=0", i, valid_D); end
    end
    imem_ready = 1'b1;
    tick();
    checks++; if (instr_D !== memWord(32'h8)) begin failures++; $display("[TB] FAIL wait_instr actual=%h expected=%h", instr_D, memWord(32'h8)); end
    checks++; if (pc_D !== 32'h8 || valid_D !== 1'b1) begin failures++; $display("[TB] FAIL wait_pcD actual=%h/%b expected=8/1", pc_D, valid_D); end
    checks++; if (imem_addr !== 32'hC) begin failures++; $display("[TB] FAIL wait_next actual=%h expected=c", imem_addr); end
  endtask

  task automatic test_redirect_wait();
    resetDut();
    imem_ready = 1'b1;
    repeat (5) tick();
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("[TB] FAIL rdw_start actual=%h expected=10", imem_addr); end
    imem_ready = 1'b0; jump = 1'b1; pc_target_E = 32'h40;
    tick();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin failures++; $display("[TB] FAIL rdw_hold1 actual=%h/%b expected=10/1", imem_addr, imem_req); end
    checks++; if (valid_D !== 1'b0) begin failures++; $display("[TB] FAIL rdw_bub1 actual=%b expected=0", valid_D); end
    tick();
    checks++; if (imem_addr !== 32'h10 || valid_D !== 1'b0) begin failures++; $display("[TB] FAIL rdw_hold2 actual=%h/%b expected=10/0", imem_addr, valid_D); end
    imem_ready = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h40) begin failures++; $display("[TB] FAIL rdw_target actual=%h expected=40", imem_addr); end
    checks++; if (valid_D !== 1'b0) begin failures++; $display("[TB] FAIL rdw_drop actual=%b/%h expected=0", valid_D, instr_D); end
    tick();
    checks++; if (instr_D !== memWord(32'h40) || pc_D !== 32'h40 || valid_D !== 1'b1) begin failures++; $display("[TB] FAIL rdw_first actual=%h@%h/%b expected=%h@40/1", instr_D, pc_D, valid_D, memWord(32'h40)); end
  endtask

  task automatic test_double_redirect();
    resetDut();
    imem_ready = 1'b1;
    repeat (5) tick();
    imem_ready = 1'b0; jump = 1'b1; pc_target_E = 32'h40;
    tick();
    pc_target_E = 32'h80;
    tick();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("[TB] FAIL dbl_hold actual=%h expected=10", imem_addr); end
    imem_ready = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h80) begin failures++; $display("[TB] FAIL dbl_target actual=%h expected=80", imem_addr); end
    tick();
    checks++; if (instr_D !== memWord(32'h80) || pc_D !== 32'h80 || valid_D !== 1'b1) begin failures++; $display("[TB] FAIL dbl_first actual=%h@%h/%b expected=%h@80/1", instr_D, pc_D, valid_D, memWord(32'h80)); end
  endtask

  task automatic test_stall();
    resetDut();
    imem_ready = 1'b1;
    repeat (9) tick();
    checks++; if (imem_addr !== 32'h20 || pc_D !== 32'h1C) begin failures++; $display("[TB] FAIL stall_start actual=%h/%h expected=20/1c", imem_addr, pc_D); end
    stall_F = 1'b1; stall_D = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h20) begin failures++; $display("[TB] FAIL stall_pcF i=%0d actual=%h expected=20", i, imem_addr); end
      checks++; if (pc_D !== 32'h1C || instr_D !== memWord(32'h1C) || valid_D !== 1'b1) begin failures++; $display("[TB] FAIL stall_D i=%0d actual=%h@%h/%b expected=%h@1c/1", i, instr_D, pc_D, valid_D, memWord(32'h1C)); end
    end
    stall_F = 1'b0; stall_D = 1'b0;
    tick();
    checks++; if (pc_D !== 32'h20 || instr_D !== memWord(32'h20)) begin failures++; $display("[TB] FAIL stall_rel1 actual=%h@%h expected=%h@20", instr_D, pc_D, memWord(32'h20)); end
    checks++; if (imem_addr !== 32'h24) begin failures++; $display("[TB] FAIL stall_next actual=%h expected=24", imem_addr); end
    tick();
    checks++; if (pc_D !== 32'h24) begin failures++; $display("[TB] FAIL stall_rel2 actual=%h expected=24", pc_D); end
  endtask

  task automatic test_async_reset();
    resetDut();
    imem_ready = 1'b1;
    repeat (3) tick();
    imem_ready = 1'b0; jump = 1'b1; pc_target_E = 32'h100;
    tick();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1 || pc_D !== 32'h4) begin failures++; $display("[TB] FAIL ar_pre actual=%h/%b/%h expected=8/1/4", imem_addr, imem_req, pc_D); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL ar_fetch actual=%b/%h expected=0/0", imem_req, imem_addr); end
    checks++; if (instr_D !== NOP || valid_D !== 1'b0 || pc_D !== 32'h0 || pc_plus4_D !== 32'h4) begin failures++; $display("[TB] FAIL ar_D actual=%h/%b/%h/%h expected=%h/0/0/4", instr_D, valid_D, pc_D, pc_plus4_D, NOP); end
    @(posedge clk);
    #1;
    rst = 1'b0; imem_ready = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("[TB] FAIL ar_restart actual=%h/%b expected=0/1", imem_addr, imem_req); end
    jump = 1'b1; pc_target_E = 32'h43;
    tick();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'h40 || valid_D !== 1'b0) begin failures++; $display("[TB] FAIL ar_align actual=%h/%b expected=40/0", imem_addr, valid_D); end
    tick();
    checks++; if (instr_D !== memWord(32'h40) || pc_D !== 32'h40 || valid_D !== 1'b1) begin failures++; $display("[TB] FAIL ar_first actual=%h@%h/%b expected=%h@40/1", instr_D, pc_D, valid_D, memWord(32'h40)); end
  endtask

  // Model: PC advances on every completed, unstalled fetch; a redirect that
  // cannot complete is remembered and applied when the pending access ends.
  task automatic test_random();
    bit          started, pending, acc;
    logic [31:0] pc, tgt, t, eInstr, ePc, eP4;
    bit          eValid;
    resetDut();
    started = 1'b0; pending = 1'b0; pc = 32'h0; tgt = 32'h0;
    eInstr = NOP; ePc = 32'h0; eP4 = 32'h4; eValid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      imem_ready  = ($urandom_range(0, 3) != 0);
      jump        = ($urandom_range(0, 7) == 0);
      stall_F     = ($urandom_range(0, 6) == 0);
      stall_D     = ($urandom_range(0, 6) == 0);
      flush_D     = ($urandom_range(0, 9) == 0);
      pc_target_E = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      t = pc_target_E & 32'hFFFF_FFFC;
      acc = started && !pending && imem_ready && !jump && !stall_F;
      if (flush_D) begin
        eInstr = NOP; eValid = 1'b0;
      end else if (!stall_D) begin
        if (acc) begin
          eInstr = memWord(pc); ePc = pc; eP4 = pc + 32'd4; eValid = 1'b1;
        end else begin
          eInstr = NOP; eValid = 1'b0;
        end
      end
      if (!started) started = 1'b1;
      else if (pending) begin
        if (jump) tgt = t;
        if (imem_ready) begin pc = tgt; pending = 1'b0; end
      end else if (jump) begin
        if (imem_ready) pc = t;
        else begin tgt = t; pending = 1'b1; end
      end else if (imem_ready && !stall_F) pc = pc + 32'd4;
      tick();
      checks++; if (imem_req !== started) begin failures++; $display("[TB] FAIL rnd_req n=%0d actual=%b expected=%b", n, imem_req, started); end
      checks++; if (imem_addr !== pc) begin failures++; $display("[TB] FAIL rnd_addr n=%0d actual=%h expected=%h", n, imem_addr, pc); end
      checks++; if (instr_D !== eInstr || valid_D !== eValid) begin failures++; $display("[TB] FAIL rnd_instr n=%0d actual=%h/%b expected=%h/%b", n, instr_D, valid_D, eInstr, eValid); end
      checks++; if (pc_D !== ePc || pc_plus4_D !== eP4) begin failures++; $display("[TB] FAIL rnd_pcD n=%0d actual=%h/%h expected=%h/%h", n, pc_D, pc_plus4_D, ePc, eP4); end
    end
    stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0; jump = 1'b0;
  endtask

  initial begin
    $display("[TB] starting fetch_stage bench");
    test_reset();
    test_sequential();
    test_wait_states();
    test_redirect_wait();
    test_double_redirect();
    test_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
